alu_operand_issue: RTL and testbench
====================================

// Module: alu_operand_issue
// PURPOSE
//  Decode->execute issue stage feeding the 64-bit ALU: registers one decoded op, selects
//  operands (rs1/PC, rs2/imm), applies MEM/WB bypass, drives op1/op2/alu_ctrl and resolves
//  branches from the ALU zero flag. Sits between decode and the alu instance in RV64 core.
// PARAMETERS
//  XLEN     64  datapath width (op1/op2/imm/pc)
//  REG_AW   5   register index width
//  CTRL_W   4   alu_ctrl width
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       async active-low reset
//  flush          in   1       kill held op (redirect)
//  id_valid       in   1       decode op valid
//  id_ready       out  1       stage can accept
//  id_rs1/id_rs2  in   REG_AW  source indices
//  id_rd          in   REG_AW  dest index
//  id_rs1_data    in   XLEN    regfile read 1
//  id_rs2_data    in   XLEN    regfile read 2
//  id_imm, id_pc  in   XLEN    immediate, op PC
//  id_src1_pc     in   1       1: op1=PC, 0: op1=rs1
//  id_src2_imm    in   1       1: op2=imm, 0: op2=rs2
//  id_alu_ctrl    in   CTRL_W  ALU op code
//  id_is_branch   in   1       conditional branch
//  id_br_inv      in   1       taken when zero==0 (else zero==1)
//  mem_wr_en/mem_rd/mem_data  in 1/REG_AW/XLEN  MEM-stage bypass source
//  wb_wr_en/wb_rd/wb_data     in 1/REG_AW/XLEN  WB-stage bypass/refresh source
//  op1, op2       out  XLEN    ALU operands
//  alu_ctrl       out  CTRL_W  ALU op code
//  alu_zero       in   1       ALU zero flag
//  ex_valid       out  1       held op valid
//  ex_ready       in   1       downstream accepts held op
//  ex_rd          out  REG_AW  held dest index
//  br_taken       out  1       branch resolved taken
//  br_target      out  XLEN    registered id_pc+id_imm
// BEHAVIOUR
//  - Reset (async, rst_n=0): ex_valid=0, all held fields=0 -> op1=op2=0, alu_ctrl=0,
//    ex_rd=0, br_taken=0, br_target=0. Release synchronous to clk.
//  - States: EMPTY (ex_valid=0), HELD (ex_valid=1). id_ready = !ex_valid | ex_ready.
//  - Capture when id_valid&id_ready: next cycle ex_valid=1, fields loaded. Latency 1 cycle.
//  - HELD & ex_ready & !id_valid -> EMPTY. HELD & !ex_ready -> hold all fields.
//  - flush: ex_valid<=0 next edge, overrides capture same cycle; fields may load, unused.
//  - Hold refresh: while held, if wb_wr_en & wb_rd!=0 & wb_rd==held rs1 (rs2), held rs
//    data <= wb_data (prevents lost write-back during stall).
//  - Bypass (comb, on held rs data): rs!=0 & mem_wr_en & mem_rd==rs -> mem_data; else
//    rs!=0 & wb_wr_en & wb_rd==rs -> wb_data; else held data. MEM beats WB. x0 never bypassed.
//  - op1 = src1_pc ? pc : rs1_fwd; op2 = src2_imm ? imm : rs2_fwd. alu_ctrl = held ctrl.
//  - br_taken = ex_valid & is_branch & (alu_zero ^ br_inv); comb, 0 when EMPTY.
//  - br_target: XLEN-bit add, wraps mod 2^XLEN, computed at capture.
//  - Capture and refresh same cycle: capture wins (new op, id_rs data used).
// CONFIGURATION
//  ALU_ISSUE_FWD_EN defined: MEM/WB bypass muxes present as above.
//  Not defined: bypass removed, op1/op2 from held data only; mem_* ignored; WB hold refresh
//  kept; decode must stall on RAW hazards.
// TESTING
//  1 reset mid-HELD: rst_n=0 -> ex_valid=0, op1=op2=0, br_taken=0 immediately.
//  2 id rs1=5 data=0x10, src2_imm imm=0x8, ctrl=ADD, ex_ready=1 -> next cycle op1=0x10,
//    op2=0x8, ex_valid=1, id_ready=1.
//  3 held rs1=3, mem_rd=3 mem_data=0xAA, wb_rd=3 wb_data=0xBB -> op1=0xAA (FWD_EN);
//    rs1=0 with mem_rd=0 -> op1=held 0; without FWD_EN op1=held value.
//  4 ex_ready=0 3 cycles, wb_rd=rs2 wb_data=0x55 once -> op2 stays 0x55 after wb drops;
//    id_ready=0 throughout, new id op not captured.
//  5 branch pc=0xFFFF_FFFF_FFFF_FFF0 imm=0x20, br_inv=0, alu_zero=1 -> br_taken=1,
//    br_target=0x10; br_inv=1 -> br_taken=0.
//  6 flush with id_valid=1 same cycle -> ex_valid=0 next cycle, br_taken=0.

Source files
------------

// File: rtl/alu_operand_issue.sv
// Decode->execute issue stage: holds one decoded op, selects ALU operands and resolves branches.
// Optional MEM/WB operand bypass is enabled by defining ALU_ISSUE_FWD_EN.
module alu_operand_issue #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              id_src1_pc,
  input  logic              id_src2_imm,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_is_branch,
  input  logic              id_br_inv,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   op1,
  output logic [XLEN-1:0]   op2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic              alu_zero,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [REG_AW-1:0] ex_rd,
  output logic              br_taken,
  output logic [XLEN-1:0]   br_target
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q, pc_q, br_target_q;
  logic              src1_pc_q, src2_imm_q, is_branch_q, br_inv_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              capture;
  logic              wb_hit_rs1, wb_hit_rs2;
  logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    id_ready = (state_q == EMPTY) || ex_ready;
    capture  = id_valid && id_ready;
    if (flush)                             state_d = EMPTY;
    else if (capture)                      state_d = HELD;
    else if (state_q == HELD && ex_ready)  state_d = EMPTY;
  end

  assign wb_hit_rs1 = wb_wr_en && (wb_rd != '0) && (wb_rd == rs1_q);
  assign wb_hit_rs2 = wb_wr_en && (wb_rd != '0) && (wb_rd == rs2_q);

  // A capture replaces the op outright, so a same-cycle WB refresh of the old op is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      br_target_q <= '0;
      src1_pc_q   <= 1'b0;
      src2_imm_q  <= 1'b0;
      is_branch_q <= 1'b0;
      br_inv_q    <= 1'b0;
      ctrl_q      <= '0;
    end else if (capture) begin
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      pc_q        <= id_pc;
      br_target_q <= id_pc + id_imm;
      src1_pc_q   <= id_src1_pc;
      src2_imm_q  <= id_src2_imm;
      is_branch_q <= id_is_branch;
      br_inv_q    <= id_br_inv;
      ctrl_q      <= id_alu_ctrl;
    end else if (state_q == HELD) begin
      if (wb_hit_rs1) rs1_data_q <= wb_data;
      if (wb_hit_rs2) rs2_data_q <= wb_data;
    end
  end

`ifdef ALU_ISSUE_FWD_EN
  // MEM is the younger producer, so it takes priority over WB.
  always_comb begin
    rs1_fwd = rs1_data_q;
    if (rs1_q != '0 && mem_wr_en && mem_rd == rs1_q) rs1_fwd = mem_data;
    else if (wb_hit_rs1)                              rs1_fwd = wb_data;
  end

  always_comb begin
    rs2_fwd = rs2_data_q;
    if (rs2_q != '0 && mem_wr_en && mem_rd == rs2_q) rs2_fwd = mem_data;
    else if (wb_hit_rs2)                              rs2_fwd = wb_data;
  end
`else
  logic unused_mem;
  assign unused_mem = ^{mem_wr_en, mem_rd, mem_data};
  assign rs1_fwd    = rs1_data_q;
  assign rs2_fwd    = rs2_data_q;
`endif

  assign ex_valid  = (state_q == HELD);
  assign op1       = src1_pc_q  ? pc_q  : rs1_fwd;
  assign op2       = src2_imm_q ? imm_q : rs2_fwd;
  assign alu_ctrl  = ctrl_q;
  assign ex_rd     = rd_q;
  assign br_target = br_target_q;
  assign br_taken  = ex_valid && is_branch_q && (alu_zero ^ br_inv_q);

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed self-checking bench for alu_operand_issue (default and ALU_ISSUE_FWD_EN builds).
module tb_alu_operand_issue;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd;
  logic [63:0] id_rs1_data, id_rs2_data, id_imm, id_pc, mem_data, wb_data;
  logic        id_src1_pc, id_src2_imm, id_is_branch, id_br_inv;
  logic [3:0]  id_alu_ctrl, alu_ctrl;
  logic        mem_wr_en, wb_wr_en, alu_zero, ex_valid, ex_ready, br_taken;
  logic [63:0] op1, op2, br_target;

  int checks = 0;
  int errors = 0;

  alu_operand_issue #(.XLEN(64), .REG_AW(5), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm), .id_alu_ctrl(id_alu_ctrl),
    .id_is_branch(id_is_branch), .id_br_inv(id_br_inv),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .op1(op1), .op2(op2), .alu_ctrl(alu_ctrl), .alu_zero(alu_zero),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                        input logic [63:0] pc, input logic s1pc, input logic s2imm,
                        input logic [3:0] ctrl, input logic br, input logic inv);
    id_valid = 1'b1;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
    id_src1_pc = s1pc; id_src2_imm = s2imm; id_alu_ctrl = ctrl;
    id_is_branch = br; id_br_inv = inv;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0; alu_zero = 1'b0;
    mem_wr_en = 1'b0; mem_rd = '0; mem_data = '0;
    wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
    set_op('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    id_valid = 1'b0;

    // Reset state
    #3;
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_op1", op1, 64'd0);
    check("rst_op2", op2, 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("rst_ex_rd", 64'(ex_rd), 64'd0);
    check("rst_br_taken", 64'(br_taken), 64'd0);
    check("rst_br_target", br_target, 64'd0);
    check("rst_id_ready", 64'(id_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic capture, 1-cycle latency
    set_op(5'd5, 5'd0, 5'd7, 64'h10, 64'h0, 64'h8, 64'h100, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    ex_ready = 1'b1;
    tick();
    id_valid = 1'b0;
    check("cap_ex_valid", 64'(ex_valid), 64'd1);
    check("cap_op1", op1, 64'h10);
    check("cap_op2", op2, 64'h8);
    check("cap_id_ready", 64'(id_ready), 64'd1);
    check("cap_ex_rd", 64'(ex_rd), 64'd7);
    check("cap_br_target", br_target, 64'h108);
    tick();
    check("drain_ex_valid", 64'(ex_valid), 64'd0);

    // Bypass priority and WB refresh
    set_op(5'd3, 5'd0, 5'd4, 64'h33, 64'h0, 64'h1, 64'h200, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
    ex_ready = 1'b0;
    tick();
    id_valid = 1'b0;
    check("byp_id_ready", 64'(id_ready), 64'd0);
    mem_wr_en = 1'b1; mem_rd = 5'd3; mem_data = 64'hAA;
    wb_wr_en = 1'b1; wb_rd = 5'd3; wb_data = 64'hBB;
    #1;
    check("byp_mem_over_wb", op1, FWD ? 64'hAA : 64'h33);
    mem_wr_en = 1'b0;
    #1;
    check("byp_wb_only", op1, FWD ? 64'hBB : 64'h33);
    tick();
    wb_wr_en = 1'b0;
    #1;
    check("refresh_rs1", op1, 64'hBB);
    check("byp_alu_ctrl", 64'(alu_ctrl), 64'h2);

    // x0 is never bypassed
    set_op(5'd0, 5'd0, 5'd2, 64'h0, 64'h0, 64'h4, 64'h300, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    ex_ready = 1'b1;
    tick();
    id_valid = 1'b0; ex_ready = 1'b0;
    mem_wr_en = 1'b1; mem_rd = 5'd0; mem_data = 64'hAA;
    wb_wr_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hBB;
    #1;
    check("x0_no_bypass", op1, 64'h0);
    tick();
    check("x0_no_refresh", op1, 64'h0);
    mem_wr_en = 1'b0; wb_wr_en = 1'b0; mem_rd = '0; wb_rd = '0;

    // Stall with WB refresh of rs2; pending decode op must wait
    set_op(5'd1, 5'd9, 5'd12, 64'h11, 64'h99, 64'h0, 64'h400, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    set_op(5'd2, 5'd9, 5'd13, 64'h22, 64'h77, 64'h0, 64'h404, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
    wb_wr_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h55;
    #1;
    check("stall_id_ready", 64'(id_ready), 64'd0);
    check("stall_op1", op1, 64'h11);
    tick();
    wb_wr_en = 1'b0; wb_rd = '0;
    #1;
    check("stall_op2_refreshed", op2, 64'h55);
    check("stall_ex_rd_c1", 64'(ex_rd), 64'd12);
    tick();
    check("stall_op2_c2", op2, 64'h55);
    check("stall_ex_valid_c2", 64'(ex_valid), 64'd1);
    tick();
    check("stall_ex_rd_c3", 64'(ex_rd), 64'd12);
    check("stall_id_ready_c3", 64'(id_ready), 64'd0);
    ex_ready = 1'b1;
    tick();
    id_valid = 1'b0;
    check("post_stall_ex_rd", 64'(ex_rd), 64'd13);
    check("post_stall_op2", op2, 64'h77);
    check("post_stall_ctrl", 64'(alu_ctrl), 64'h5);
    tick();
    check("post_stall_empty", 64'(ex_valid), 64'd0);

    // Branch resolve with wrapping target
    set_op(5'd0, 5'd0, 5'd1, 64'h0, 64'h0, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0,
           1'b1, 1'b1, 4'h0, 1'b1, 1'b0);
    alu_zero = 1'b1; ex_ready = 1'b0;
    tick();
    id_valid = 1'b0;
    check("br_taken_zero", 64'(br_taken), 64'd1);
    check("br_target_wrap", br_target, 64'h10);
    check("br_op1_pc", op1, 64'hFFFF_FFFF_FFFF_FFF0);
    alu_zero = 1'b0;
    #1;
    check("br_not_taken_nz", 64'(br_taken), 64'd0);
    ex_ready = 1'b1;
    set_op(5'd0, 5'd0, 5'd1, 64'h0, 64'h0, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0,
           1'b1, 1'b1, 4'h0, 1'b1, 1'b1);
    alu_zero = 1'b1;
    tick();
    id_valid = 1'b0; ex_ready = 1'b0;
    check("br_inv_zero", 64'(br_taken), 64'd0);
    alu_zero = 1'b0;
    #1;
    check("br_inv_nz", 64'(br_taken), 64'd1);

    // Flush overrides same-cycle capture
    flush = 1'b1; ex_ready = 1'b1;
    set_op(5'd4, 5'd0, 5'd6, 64'h1, 64'h0, 64'h4, 64'h600, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
    tick();
    flush = 1'b0; id_valid = 1'b0;
    check("flush_ex_valid", 64'(ex_valid), 64'd0);
    check("flush_br_taken", 64'(br_taken), 64'd0);
    check("flush_id_ready", 64'(id_ready), 64'd1);
    tick();
    check("flush_stays_empty", 64'(ex_valid), 64'd0);

    // Asynchronous reset while holding a taken branch
    set_op(5'd5, 5'd6, 5'd8, 64'h1234, 64'h5678, 64'h40, 64'h500, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1);
    ex_ready = 1'b0; alu_zero = 1'b0;
    tick();
    id_valid = 1'b0;
    check("pre_rst_br_taken", 64'(br_taken), 64'd1);
    check("pre_rst_op1", op1, 64'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ex_valid", 64'(ex_valid), 64'd0);
    check("async_rst_op1", op1, 64'd0);
    check("async_rst_op2", op2, 64'd0);
    check("async_rst_br_taken", 64'(br_taken), 64'd0);
    check("async_rst_br_target", br_target, 64'd0);
    check("async_rst_ex_rd", 64'(ex_rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
